// File: rtl/rgb_sram_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_sram_streamer
//  Purpose  : Reads the packed RGB frame from external SRAM (3 words hold
//             2 pixels) and streams it out as 24-bit pixels over a
//             valid/ready handshake. A small word FIFO absorbs the 2-cycle
//             SRAM read latency so reads can be issued back to back.
//  Ports    : Clock, Reset (async, active-high), Start
//             SRAM_address / SRAM_read_data / SRAM_we_n : read-only SRAM port
//             Pixel_valid / Pixel_ready / Pixel_R,G,B  : pixel stream
//             Busy (frame in progress), Done (one-cycle end-of-frame pulse)
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_sram_streamer #(
    parameter logic [17:0] RGB_BASE_ADDRESS = 18'd146944,
    parameter int          PIXEL_COUNT      = 76800,
    parameter int          FIFO_DEPTH       = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic        Pixel_valid,
    input  logic        Pixel_ready,
    output logic [7:0]  Pixel_R,
    output logic [7:0]  Pixel_G,
    output logic [7:0]  Pixel_B,
    output logic        Busy,
    output logic        Done
);

    localparam int WORD_COUNT = PIXEL_COUNT * 3 / 2;
    localparam int WCNT_W     = $clog2(WORD_COUNT + 1);
    localparam int PCNT_W     = $clog2(PIXEL_COUNT + 1);
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [WCNT_W-1:0] WORD_TOTAL = WCNT_W'(WORD_COUNT);
    localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(WORD_COUNT - 1);
    localparam logic [PCNT_W-1:0] LAST_PIXEL = PCNT_W'(PIXEL_COUNT - 1);
    localparam logic [PTR_W-1:0]  LAST_SLOT  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [OCC_W:0]    DEPTH_EXT  = (OCC_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [WCNT_W-1:0] word_cnt;
    logic [PCNT_W-1:0] pix_cnt;
    logic              phase;      // 0: next pixel is the even one of its group
    logic [1:0]        issue_sr;   // [0]: issued last cycle, [1]: data on the bus now

    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  occ;

    logic              issue;
    logic              wr;
    logic [OCC_W:0]    pending;
    logic [OCC_W-1:0]  avail;
    logic [OCC_W-1:0]  pop_cnt;
    logic [PTR_W-1:0]  rd_ptr1;
    logic [15:0]       head;
    logic [15:0]       head1;
    logic              accept;
    logic              load;
    logic              last_accept;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
    endfunction

    // Issue decision uses only registered state, so Pixel_ready never reaches
    // SRAM_address combinationally. Counting in-flight reads against free
    // FIFO slots guarantees every returning word has a place to land.
    assign pending = {1'b0, occ} + (OCC_W + 1)'(issue_sr[0]) + (OCC_W + 1)'(issue_sr[1]);
    assign issue   = (state == S_RUN) && (pending < DEPTH_EXT) && (word_cnt < WORD_TOTAL);
    assign wr      = issue_sr[1];

    // The word arriving this cycle counts as available and is bypassed
    // straight to the unpacker, saving a cycle of start-up latency.
    assign avail   = occ + OCC_W'(wr);
    assign rd_ptr1 = next_ptr(rd_ptr);
    assign head    = (occ != '0)       ? fifo_mem[rd_ptr]  : SRAM_read_data;
    assign head1   = (occ > OCC_W'(1)) ? fifo_mem[rd_ptr1] : SRAM_read_data;

    assign accept      = Pixel_valid && Pixel_ready;
    assign last_accept = accept && (pix_cnt == LAST_PIXEL);
    // Both pixel phases look at two words; even pops one (keeps the shared
    // middle word at the head), odd pops two.
    assign load        = (avail >= OCC_W'(2)) && (!Pixel_valid || accept);
    assign pop_cnt     = load ? (phase ? OCC_W'(2) : OCC_W'(1)) : '0;

    always_ff @(posedge Clock) begin
        if (wr) begin
            fifo_mem[wr_ptr] <= SRAM_read_data;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= S_IDLE;
            word_cnt     <= '0;
            pix_cnt      <= '0;
            phase        <= 1'b0;
            issue_sr     <= 2'b00;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occ          <= '0;
            SRAM_address <= RGB_BASE_ADDRESS;
            SRAM_we_n    <= 1'b1;
            Pixel_valid  <= 1'b0;
            Pixel_R      <= 8'd0;
            Pixel_G      <= 8'd0;
            Pixel_B      <= 8'd0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            SRAM_we_n <= 1'b1;
            issue_sr  <= {issue_sr[0], issue};
            Done      <= last_accept;

            // Word FIFO bookkeeping
            if (wr) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (load) begin
                rd_ptr <= phase ? next_ptr(rd_ptr1) : rd_ptr1;
            end
            occ <= occ + OCC_W'(wr) - pop_cnt;

            // Output register
            if (load) begin
                Pixel_valid <= 1'b1;
                phase       <= ~phase;
                if (!phase) begin
                    {Pixel_R, Pixel_G, Pixel_B} <= {head, head1[15:8]};
                end else begin
                    {Pixel_R, Pixel_G, Pixel_B} <= {head[7:0], head1};
                end
            end else if (accept) begin
                Pixel_valid <= 1'b0;
            end

            if (accept) begin
                pix_cnt <= pix_cnt + PCNT_W'(1);
            end
            if (issue) begin
                word_cnt <= word_cnt + WCNT_W'(1);
            end

            // Address: advances only on issue; parked at base outside a frame.
            if (last_accept || state == S_DONE || state == S_IDLE) begin
                SRAM_address <= RGB_BASE_ADDRESS;
            end else if (issue) begin
                SRAM_address <= SRAM_address + 18'd1;
            end

            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state <= S_RUN;
                        Busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (issue && word_cnt == LAST_WORD) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_accept) begin
                        state <= S_DONE;
                        Busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Frame counters clear as the frame ends.
            if (last_accept) begin
                word_cnt <= '0;
                pix_cnt  <= '0;
                phase    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/rgb_sram_streamer.md
# rgb_sram_streamer

Reads the packed RGB frame that the colour-space conversion stage writes to external SRAM and delivers it as a stream of 24-bit pixels over a valid/ready handshake. It is the stage directly downstream of the YUV-to-RGB converter and feeds the display/readback path. It hides the 2-cycle SRAM read latency behind a small word FIFO and unpacks 3 SRAM words into 2 pixels.

## Interface
- RGB_BASE_ADDRESS, 18'd146944: SRAM word address of the first RGB word.
- PIXEL_COUNT, 76800: pixels per frame. Must be even. Word count is PIXEL_COUNT*3/2.
- FIFO_DEPTH, 4: word FIFO depth. Must be at least 3.
- Clock, in, 1: single clock, rising edge.
- Reset, in, 1: asynchronous, active-high reset.
- Start, in, 1: begin one frame. Sampled only in S_IDLE.
- SRAM_address, out, 18: read address.
- SRAM_read_data, in, 16: read data, returned 2 cycles after its address.
- SRAM_we_n, out, 1: held at 1 (read-only block).
- Pixel_valid, out, 1: the Pixel_R/G/B outputs hold a pixel.
- Pixel_ready, in, 1: the consumer accepts a pixel.
- Pixel_R, Pixel_G, Pixel_B, out, 8 each: pixel components.
- Busy, out, 1: high from the cycle after Start is accepted until Done.
- Done, out, 1: one-cycle pulse after the last pixel is accepted.

## Operation
- **Reset values:** SRAM_address=RGB_BASE_ADDRESS, SRAM_we_n=1, Pixel_valid=0, Pixel_R/G/B=0, Busy=0, Done=0, FIFO empty, all counters 0, state S_IDLE.
- **Packing:** each 3-word group holds 2 pixels.
  - w0[15:8]=R0, w0[7:0]=G0, w1[15:8]=B0
  - w1[7:0]=R1, w2[15:8]=G1, w2[7:0]=B1
- **States:**
  - S_IDLE: Start=1 -> S_RUN. SRAM_address holds RGB_BASE_ADDRESS. Start is ignored in every other state.
  - S_RUN: issues reads and unpacks words. After the last word address is issued -> S_DRAIN.
  - S_DRAIN: no new reads. When the last pixel is accepted -> S_DONE.
  - S_DONE: Done=1 for one cycle, Busy=0, SRAM_address returns to the base, -> S_IDLE.
- **Read issue:** a read is issued in a cycle only if (FIFO occupancy + reads in flight) < FIFO_DEPTH and the word counter is below PIXEL_COUNT*3/2.
  - On issue, SRAM_address increments by 1 for the next cycle.
  - With no issue, the address holds.
  - The in-flight count is tracked with a 2-stage issue shift register. Returned data is written to the FIFO exactly 2 cycles after issue.
  - The FIFO never overflows. Overflow is a verification error.
- **Unpack:** a 1-bit phase selects the even or odd pixel.
  - Even pixel: needs 2 words in the FIFO. Pops w0 only; keeps w1 at the FIFO head.
  - Odd pixel: needs w1 and w2. Pops both.
- **Output register:** loads when it is empty, or when the current pixel is being accepted in this cycle and the next pixel's words are present.
  - This gives back-to-back transfers with no bubble.
- **Handshake:** a transfer happens when Pixel_valid && Pixel_ready.
  - While Pixel_valid=1 && Pixel_ready=0, Pixel_R/G/B stay stable and Pixel_valid stays high.
  - Pixel_valid never drops without a transfer.
- **Last pixel:** when pixel PIXEL_COUNT-1 is accepted, Pixel_valid goes to 0 on the next cycle and Done pulses that same cycle.
- **Address range:** with the defaults, the last word address is 262143. The incremented address wraps to 0 but is never issued. SRAM_address returns to the base in S_DONE.
- **Reset mid-frame:** every register returns to its reset value immediately. In-flight SRAM data is discarded.

## Timing
- **Start latency:** Start is sampled high at edge 0. Busy=1 and the first read (base address) is issued in cycle 1. Word 0 is captured at the end of cycle 3 and word 1 at the end of cycle 4. Pixel_valid rises in cycle 5.
- **Throughput:** 1 word/cycle, i.e. 2 pixels per 3 cycles with Pixel_ready held high. Pixel_valid shows the periodic pattern 1,1,0 once the pipeline is full.
- **Back-pressure:** after Pixel_ready deasserts, issue stops within 2 cycles of the FIFO filling.
- **Recovery:** when Pixel_ready reasserts, the next pixel follows the accepted one in the next cycle if its words are already buffered.
- **Combinational paths:** no combinational path from Pixel_ready to SRAM_address. Pixel_ready may feed the FIFO pop and the output-register load enable. Every output is registered.

## Test plan
- **Small frame:** PIXEL_COUNT=4, SRAM model words 0xAABB, 0xCCDD, 0xEEFF at base..base+2 and 0x1122, 0x3344, 0x5566 after them, Pixel_ready=1 -> pixels (AA,BB,CC), (DD,EE,FF), (11,22,33), (44,55,66); first Pixel_valid in cycle 5; Done one cycle after the 4th transfer; exactly 6 reads issued.
- **Back-pressure:** Pixel_ready toggled randomly, PIXEL_COUNT=16 -> identical pixel sequence; outputs stable while stalled; issued-minus-consumed words never exceed 4.
- **Start while busy:** Start pulsed during S_RUN -> ignored; exactly one Done; the next Start after Done restarts from RGB_BASE_ADDRESS.
- **Reset mid-frame:** Reset after 5 pixels -> Pixel_valid=0, Busy=0, SRAM_address=146944 asynchronously; a new Start streams pixel 0 correctly.
- **Full default frame:** PIXEL_COUNT=76800 -> last address issued 262143; 115200 reads; 76800 pixels; SRAM_we_n=1 throughout.
